// File: rtl/prio_bcd_enc_if.sv
// -----------------------------------------------------------------------------
// prio_bcd_enc_if
//
// Request/result bus of the priority-to-BCD encoder. It carries both
// valid/ready handshakes: the request side (in_valid, in_ready, y) and the
// result side (out_valid, out_ready, bcd, none, multi).
//
// Parameters:
//   N      - number of request lines (width of y)
//   DIGITS - number of packed BCD digits on bcd
//
// Modports:
//   master - the side that drives requests and consumes results
//   slave  - the encoder itself
// -----------------------------------------------------------------------------
interface prio_bcd_enc_if #(
    parameter int N      = 100,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N-1:0]          y;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  none;
    logic                  multi;

    modport master (
        output in_valid, y, out_ready,
        input  in_ready, out_valid, bcd, none, multi
    );

    modport slave (
        input  in_valid, y, out_ready,
        output in_ready, out_valid, bcd, none, multi
    );
endinterface

// File: rtl/prio_bcd_enc.sv
// -----------------------------------------------------------------------------
// prio_bcd_enc
//
// Registered priority encoder. It captures an N-line request vector and finds
// the highest set line. It then converts that index to packed BCD with a serial
// double-dabble converter that produces one bit per cycle. The block holds one
// transaction at a time. Both sides use valid/ready handshakes.
//
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous, active-high reset; drops any transaction in flight
//   bus  - prio_bcd_enc_if.slave:
//            in_valid/in_ready/y                 request side
//            out_valid/out_ready/bcd/none/multi  result side
//            bcd[3:0] is the units digit
//
// Parameters:
//   N      - request lines, 2..1024
//   DIGITS - BCD output digits; 10**DIGITS must be at least N
//
// Compile-time option:
//   PRIO_BCD_ENC_MULTI_CHECK_EN - when defined, multi reports that two or more
//   lines were set at acceptance. When undefined, that logic is absent and
//   multi is always 0. Priority selection is the same in both builds.
//
// Latency: IDX_W+1 edges from acceptance to out_valid (IDX_W = $clog2(N)).
// -----------------------------------------------------------------------------
module prio_bcd_enc #(
    parameter int N      = 100,
    parameter int DIGITS = 3
) (
    input  logic           clk,
    input  logic           rst,
    prio_bcd_enc_if.slave  bus
);
    localparam int IDX_W = $clog2(N);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IDX_W + 1);

    // True when DIGITS decimal digits can represent every index 0..lines-1.
    function automatic bit digits_cover(input int digits, input int lines);
        longint p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            if (p < lines) p = p * 10;
        end
        return p >= longint'(lines);
    endfunction

    if (N < 2 || N > 1024) begin : g_bad_n
        $error("prio_bcd_enc: N=%0d outside legal range 2..1024", N);
    end
    if (!digits_cover(DIGITS, N)) begin : g_bad_digits
        $error("prio_bcd_enc: DIGITS=%0d cannot hold index %0d", DIGITS, N - 1);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic [BCD_W-1:0]     acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 none_q, multi_q;
    logic [BCD_W-1:0]     bcd_q;
    logic                 none_o, multi_o;

    logic [IDX_W-1:0]     pri_idx;
    logic                 seen;
    logic                 none_c, multi_c;
    logic [BCD_W-1:0]     acc_adj, acc_shift;
    logic                 in_ready_c, out_valid_c;

    // Priority selection. The scan runs upward, so a later (higher) set line
    // overwrites an earlier one and the highest index wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update.
        // A path that leaves one unassigned would infer a latch.
        pri_idx = '0;
        seen    = 1'b0;
        multi_c = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.y[i]) begin
                pri_idx = IDX_W'(i);
`ifdef PRIO_BCD_ENC_MULTI_CHECK_EN
                multi_c = multi_c | seen;
`endif
                seen    = 1'b1;
            end
        end
        none_c = ~seen;
    end

    // One double-dabble step. Digits >= 5 get +3, judged on the pre-shift
    // value. Then {acc, idx} shifts left and the idx MSB enters the acc LSB.
    always_comb begin
        acc_adj = acc_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5)
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
        end
        if (BCD_W > 1)
            acc_shift = {acc_adj[BCD_W-2:0], idx_q[IDX_W-1]};
        else
            acc_shift = idx_q[IDX_W-1];
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= so that every register
        // samples pre-edge values, whatever order the statements are in.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)           state_d = CONV;
            CONV:    if (cnt_q == CNT_W'(1))     state_d = DONE;
            DONE:    if (bus.out_ready)          state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Output decode. These depend only on the state, so no input reaches
    // in_ready or out_valid combinationally.
    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE:    in_ready_c  = 1'b1;
            DONE:    out_valid_c = 1'b1;
            default: ;
        endcase
    end

    // Datapath. The result registers load only on the last conversion step.
    // They keep their value through DONE and after it, until the next result
    // or a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            none_q  <= 1'b0;
            multi_q <= 1'b0;
            bcd_q   <= '0;
            none_o  <= 1'b0;
            multi_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        idx_q   <= pri_idx;
                        none_q  <= none_c;
                        multi_q <= multi_c;
                        cnt_q   <= CNT_W'(IDX_W);
                        acc_q   <= '0;
                    end
                end
                CONV: begin
                    acc_q <= acc_shift;
                    idx_q <= idx_q << 1;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q   <= acc_shift;
                        none_o  <= none_q;
                        multi_o <= multi_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.bcd       = bcd_q;
    assign bus.none      = none_o;
    assign bus.multi     = multi_o;

endmodule

// File: tb/tb_prio_bcd_enc.sv
// -----------------------------------------------------------------------------
// tb_prio_bcd_enc
//
// Directed bench for prio_bcd_enc. The main instance uses N=100, DIGITS=3.
// A second instance uses the legacy width N=10, DIGITS=1. Expected values are
// hand-computed. Inputs change on the falling edge and outputs are sampled
// there too, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_prio_bcd_enc;
    localparam int N   = 100;
    localparam int DG  = 3;
    localparam int N10 = 10;
    localparam int D10 = 1;

`ifdef PRIO_BCD_ENC_MULTI_CHECK_EN
    localparam bit MULTI_ON = 1'b1;
`else
    localparam bit MULTI_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    prio_bcd_enc_if #(.N(N),   .DIGITS(DG))  bus ();
    prio_bcd_enc_if #(.N(N10), .DIGITS(D10)) bus10 ();

    prio_bcd_enc #(.N(N), .DIGITS(DG)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    prio_bcd_enc #(.N(N10), .DIGITS(D10)) u_dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present y on the main instance for one acceptance edge, then wait for
    // out_valid. lat counts edges with the acceptance edge as 1.
    task automatic send100(input logic [N-1:0] yv, output int lat);
        bus.y        = yv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic release100();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("in_ready_after_release", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_vec(input string tag, input logic [N-1:0] yv,
                          input logic [11:0] exp_bcd, input logic exp_none,
                          input logic exp_multi_raw);
        int lat;
        send100(yv, lat);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_bcd"},     32'(bus.bcd), 32'(exp_bcd));
        check({tag, "_none"},    32'(bus.none), 32'(exp_none));
        check({tag, "_multi"},   32'(bus.multi), 32'(exp_multi_raw & MULTI_ON));
        release100();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0]   v;
        logic [N10-1:0] v10;
        logic           ok;
        int             lat;

        bus.in_valid   = 1'b0;
        bus.y          = '0;
        bus.out_ready  = 1'b0;
        bus10.in_valid  = 1'b0;
        bus10.y         = '0;
        bus10.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_bcd",       32'(bus.bcd), 32'd0);
        check("rst_none",      32'(bus.none), 32'd0);
        check("rst_multi",     32'(bus.multi), 32'd0);

        // Directed vectors on the N=100 instance.
        v = '0; v[57] = 1'b1;                     do_vec("bit57",    v, 12'h057, 1'b0, 1'b0);
        v = '0; v[99] = 1'b1; v[3] = 1'b1;        do_vec("b99_b3",   v, 12'h099, 1'b0, 1'b1);
        v = '0;                                   do_vec("zero",     v, 12'h000, 1'b1, 1'b0);
        v = '0; v[0] = 1'b1;                      do_vec("bit0",     v, 12'h000, 1'b0, 1'b0);
        v = '0; v[10] = 1'b1;                     do_vec("bit10",    v, 12'h010, 1'b0, 1'b0);
        v = '0; v[89] = 1'b1;                     do_vec("bit89",    v, 12'h089, 1'b0, 1'b0);
        v = '0; v[99] = 1'b1;                     do_vec("bit99",    v, 12'h099, 1'b0, 1'b0);
        v = '0; v[65] = 1'b1; v[64] = 1'b1; v[63] = 1'b1;
                                                  do_vec("b65_64_63", v, 12'h065, 1'b0, 1'b1);

        // Back-pressure: hold out_ready low for 20 cycles in DONE while a
        // new request is offered. Neither the result nor the state may move.
        v = '0; v[64] = 1'b1; v[7] = 1'b1;
        send100(v, lat);
        check("bp_latency", 32'(lat), 32'd8);
        check("bp_bcd",     32'(bus.bcd), 32'h064);
        check("bp_multi",   32'(bus.multi), 32'(MULTI_ON));
        v = '0; v[5] = 1'b1;
        bus.y        = v;
        bus.in_valid = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.bcd !== 12'h064 || bus.in_ready !== 1'b0)
                ok = 1'b0;
        end
        check("bp_stable", 32'(ok), 32'd1);
        bus.in_valid = 1'b0;
        release100();
        check("bp_out_valid_low", 32'(bus.out_valid), 32'd0);
        check("bp_bcd_held",      32'(bus.bcd), 32'h064);

        // Reset in the third CONV cycle drops the transaction.
        v = '0; v[88] = 1'b1;
        bus.y        = v;
        bus.in_valid = 1'b1;
        tick();                       // acceptance edge; now in CONV cycle 1
        bus.in_valid = 1'b0;
        tick();                       // CONV cycle 2
        tick();                       // CONV cycle 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready",  32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_bcd",       32'(bus.bcd), 32'd0);
        v = '0; v[42] = 1'b1;                     do_vec("after_rst_bit42", v, 12'h042, 1'b0, 1'b0);

        // Legacy width N=10, DIGITS=1: latency 5, bcd equals the line index.
        for (int i = 0; i <= 10; i++) begin
            v10 = '0;
            if (i < 10) v10[i] = 1'b1;
            bus10.y        = v10;
            bus10.in_valid = 1'b1;
            tick();
            bus10.in_valid = 1'b0;
            lat = 1;
            while (bus10.out_valid !== 1'b1 && lat < 40) begin
                tick();
                lat++;
            end
            check($sformatf("n10_line%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("n10_line%0d_bcd", i), 32'(bus10.bcd), (i < 10) ? 32'(i) : 32'd0);
            check($sformatf("n10_line%0d_none", i), 32'(bus10.none), (i < 10) ? 32'd0 : 32'd1);
            bus10.out_ready = 1'b1;
            tick();
            bus10.out_ready = 1'b0;
        end
        check("n10_in_ready_end", 32'(bus10.in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
